// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the multiply/divide engine that writes HiLo.
// Holds the operand width, the operation codes, the FSM state encoding and
// small op-classification helpers used by the datapath.
package mul_div_unit_pkg;

  localparam int DW = 32;

  // Operation codes presented on Op
  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MADD  = 4'd4;
  localparam logic [3:0] OP_MADDU = 4'd5;
  localparam logic [3:0] OP_MSUB  = 4'd6;
  localparam logic [3:0] OP_MSUBU = 4'd7;
  localparam logic [3:0] OP_MTHI  = 4'd8;
  localparam logic [3:0] OP_MTLO  = 4'd9;

  // FSM state encoding
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_MUL  = 3'd1;
  localparam logic [2:0] ST_DIV  = 3'd2;
  localparam logic [2:0] ST_FIN  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  // Any op that needs the shift-add multiplier (plain and accumulating)
  function automatic logic op_is_mul(input logic [3:0] op);
    return op inside {OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
  endfunction

  function automatic logic op_is_div(input logic [3:0] op);
    return op inside {OP_DIV, OP_DIVU};
  endfunction

  // Ops whose operands are two's-complement and need magnitude conversion
  function automatic logic op_is_signed(input logic [3:0] op);
    return op inside {OP_MULT, OP_DIV, OP_MADD, OP_MSUB};
  endfunction

  // Codes above MTLO are undefined: they complete but never write HiLo
  function automatic logic op_is_valid(input logic [3:0] op);
    return op <= OP_MTLO;
  endfunction

endpackage

// File: rtl/mul_div_unit_div_step.sv
// One restoring-division iteration, purely combinational.
// Shifts the next dividend bit into the partial remainder, trial-subtracts
// the divisor and keeps the difference only when it does not go negative.
// Ports:
//   rem_in  [W-1:0]  partial remainder before this step
//   dvd_bit          next dividend bit (MSB first)
//   divisor [W-1:0]  divisor magnitude
//   rem_out [W-1:0]  partial remainder after this step
//   q_bit            quotient bit produced by this step
module mul_div_unit_div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem_in,
  input  logic         dvd_bit,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_out,
  output logic         q_bit
);

  logic [W:0] shifted;

  always_comb begin
    shifted = {rem_in, dvd_bit};
    q_bit   = (shifted >= {1'b0, divisor});
    // Remainder always stays below the divisor, so W bits suffice
    rem_out = q_bit ? W'(shifted - {1'b0, divisor}) : shifted[W-1:0];
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide engine and sole writer of the 2*DW HiLo register.
// A Start pulse in IDLE latches Op/A/B/HiLoCur; multiplies and divides take
// DW iterations on magnitudes, FIN applies signs / accumulation / partial
// writes, DONE presents the result with a one-cycle write enable.
// Ports:
//   Clk, Rst            clock, synchronous active-high reset
//   Start               request pulse, accepted only while Busy=0
//   Op [3:0]            operation code (see mul_div_unit_pkg)
//   A, B [DW-1:0]       rs / rt operands
//   HiLoCur [2DW-1:0]   current HiLo, sampled at accept
//   Busy                high in every non-IDLE state
//   Done                one-cycle completion pulse
//   HiLoWrEn            one-cycle HiLo write enable (not for undefined ops)
//   HiLoOut [2DW-1:0]   {Hi,Lo} result, held between operations
// Handshake: Start is a single-cycle request qualified by Busy=0; there is no
// queue, so a Start seen while Busy=1 is dropped. Done/HiLoWrEn are asserted
// together in the DONE cycle and HiLoOut is valid from then on.
module mul_div_unit
  import mul_div_unit_pkg::*;
(
  input  logic            Clk,
  input  logic            Rst,
  input  logic            Start,
  input  logic [3:0]      Op,
  input  logic [DW-1:0]   A,
  input  logic [DW-1:0]   B,
  input  logic [2*DW-1:0] HiLoCur,
  output logic            Busy,
  output logic            Done,
  output logic            HiLoWrEn,
  output logic [2*DW-1:0] HiLoOut
);

  localparam int CW = $clog2(DW);

  logic [2:0]      state;
  logic [CW-1:0]   cnt;
  logic [3:0]      op_r;
  logic [DW-1:0]   a_raw;        // unmodified A for MTHI/MTLO and div-by-zero
  logic [2*DW-1:0] hilo_cur_r;
  logic [DW-1:0]   hi_r;         // product high half / partial remainder
  logic [DW-1:0]   lo_r;         // multiplier -> product low / dividend -> quotient
  logic [DW-1:0]   opnd_r;       // multiplicand or divisor magnitude
  logic            neg_q;        // negate product or quotient in FIN
  logic            neg_r;        // negate remainder in FIN
  logic            div_zero;

  logic            sgn;
  logic [DW-1:0]   a_mag;
  logic [DW-1:0]   b_mag;
  logic [DW:0]     mul_sum;
  logic [DW-1:0]   rem_next;
  logic            q_bit;
  logic [2*DW-1:0] prod;
  logic [DW-1:0]   quo;
  logic [DW-1:0]   rem;
  logic [2*DW-1:0] fin_result;

  assign Busy     = (state != ST_IDLE);
  assign Done     = (state == ST_DONE);
  assign HiLoWrEn = Done && op_is_valid(op_r);

  // Operand magnitudes for the accept cycle
  always_comb begin
    sgn   = op_is_signed(Op);
    a_mag = (sgn && A[DW-1]) ? -A : A;
    b_mag = (sgn && B[DW-1]) ? -B : B;
  end

  // Shift-add multiply step: add multiplicand into the high half when the
  // current multiplier bit is set, then shift the whole product right.
  assign mul_sum = {1'b0, hi_r} + (lo_r[0] ? {1'b0, opnd_r} : '0);

  mul_div_unit_div_step #(.W(DW)) u_div_step (
    .rem_in  (hi_r),
    .dvd_bit (lo_r[DW-1]),
    .divisor (opnd_r),
    .rem_out (rem_next),
    .q_bit   (q_bit)
  );

  // Final result formation from the magnitude results
  always_comb begin
    prod = neg_q ? -{hi_r, lo_r} : {hi_r, lo_r};
    quo  = neg_q ? -lo_r : lo_r;
    rem  = neg_r ? -hi_r : hi_r;
    case (op_r)
      OP_MULT, OP_MULTU: fin_result = prod;
      OP_MADD, OP_MADDU: fin_result = hilo_cur_r + prod;
      OP_MSUB, OP_MSUBU: fin_result = hilo_cur_r - prod;
      OP_DIV, OP_DIVU:   fin_result = div_zero ? {a_raw, {DW{1'b1}}} : {rem, quo};
      OP_MTHI:           fin_result = {a_raw, hilo_cur_r[DW-1:0]};
      OP_MTLO:           fin_result = {hilo_cur_r[2*DW-1:DW], a_raw};
      default:           fin_result = HiLoOut;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      op_r       <= '0;
      a_raw      <= '0;
      hilo_cur_r <= '0;
      hi_r       <= '0;
      lo_r       <= '0;
      opnd_r     <= '0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      div_zero   <= 1'b0;
      HiLoOut    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (Start) begin
            op_r       <= Op;
            a_raw      <= A;
            hilo_cur_r <= HiLoCur;
            neg_q      <= sgn && (A[DW-1] ^ B[DW-1]);
            neg_r      <= sgn && A[DW-1];
            div_zero   <= op_is_div(Op) && (B == '0);
            cnt        <= '0;
            hi_r       <= '0;
            if (op_is_mul(Op)) begin
              lo_r   <= b_mag;
              opnd_r <= a_mag;
              state  <= ST_MUL;
            end else if (op_is_div(Op)) begin
              lo_r   <= a_mag;
              opnd_r <= b_mag;
              state  <= (B == '0) ? ST_FIN : ST_DIV;
            end else begin
              state  <= ST_FIN;
            end
          end
        end
        ST_MUL: begin
          {hi_r, lo_r} <= {mul_sum, lo_r[DW-1:1]};
          cnt          <= cnt + 1'b1;
          if (cnt == CW'(DW - 1)) state <= ST_FIN;
        end
        ST_DIV: begin
          hi_r <= rem_next;
          lo_r <= {lo_r[DW-2:0], q_bit};
          cnt  <= cnt + 1'b1;
          if (cnt == CW'(DW - 1)) state <= ST_FIN;
        end
        ST_FIN: begin
          HiLoOut <= fin_result;
          state   <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Start;
  logic [3:0]  Op;
  logic [31:0] A;
  logic [31:0] B;
  logic [63:0] HiLoCur;
  logic        Busy;
  logic        Done;
  logic        HiLoWrEn;
  logic [63:0] HiLoOut;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  mul_div_unit dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .Start    (Start),
    .Op       (Op),
    .A        (A),
    .B        (B),
    .HiLoCur  (HiLoCur),
    .Busy     (Busy),
    .Done     (Done),
    .HiLoWrEn (HiLoWrEn),
    .HiLoOut  (HiLoOut)
  );

  // ---------------- clock / reset ----------------
  always #5 Clk = ~Clk;

  // ---------------- reference model ----------------
  function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] cur);
    longint sa, sb, ua, ub, q, r;
    logic [63:0] ps, pu, qv, rv;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'h0, a};
    ub = {32'h0, b};
    ps = sa * sb;
    pu = ua * ub;
    model = cur;
    case (op)
      4'd0: model = ps;
      4'd1: model = pu;
      4'd2, 4'd3: begin
        if (b == 32'h0) model = {a, 32'hFFFF_FFFF};
        else begin
          if (op == 4'd2) begin q = sa / sb; r = sa % sb; end
          else            begin q = ua / ub; r = ua % ub; end
          qv = q;
          rv = r;
          model = {rv[31:0], qv[31:0]};
        end
      end
      4'd4: model = cur + ps;
      4'd5: model = cur + pu;
      4'd6: model = cur - ps;
      4'd7: model = cur - pu;
      4'd8: model = {a, cur[31:0]};
      4'd9: model = {cur[63:32], a};
      default: model = cur;
    endcase
  endfunction

  function automatic int latency(input logic [3:0] op, input logic [31:0] b);
    if (op <= 4'd7 && !((op == 4'd2 || op == 4'd3) && b == 32'h0)) return 34;
    return 2;
  endfunction

  // Model state: posedges remaining until the in-flight op's DONE cycle ends
  int          left = 0;
  logic        pend_valid = 1'b0;
  logic [63:0] exp_hilo = 64'h0;
  logic [63:0] exp_q[$];

  always @(posedge Clk) begin
    if (Rst) begin
      left = 0;
      exp_hilo = 64'h0;
      exp_q.delete();
    end else if (left > 0) begin
      left = left - 1;
      if (left == 1 && pend_valid && exp_q.size() > 0) exp_hilo = exp_q.pop_front();
    end else if (Start) begin
      left = latency(Op, B);
      pend_valid = (Op <= 4'd9);
      if (pend_valid) exp_q.push_back(model(Op, A, B, HiLoCur));
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge Clk) begin
    chk("busy", 64'(Busy), 64'(left > 0));
    chk("done", 64'(Done), 64'(left == 1));
    chk("wren", 64'(HiLoWrEn), 64'(left == 1 && pend_valid));
    chk("hilo", HiLoOut, exp_hilo);
    if (Done) done_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s timeout t=%0t", name, $time);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (Busy && n < 200) begin
      @(negedge Clk);
      n++;
    end
    if (Busy) timeout_fail("wait_idle");
  endtask

  task automatic start_op(input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] cur);
    Op = op; A = a; B = b; HiLoCur = cur; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
  endtask

  // Issue from idle and measure negedges until Done is seen
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] cur, output int lat);
    wait_idle();
    start_op(op, a, b, cur);
    lat = 1;
    while (!Done && lat < 100) begin
      @(negedge Clk);
      lat++;
    end
    if (!Done) timeout_fail("run_op");
    @(negedge Clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    int d0;
    logic [3:0]  rop;
    logic [31:0] ra, rb;

    Rst = 1'b1; Start = 1'b0; Op = 4'd0; A = '0; B = '0; HiLoCur = '0;
    repeat (3) @(negedge Clk);
    chk("rst_busy", 64'(Busy), 64'd0);
    chk("rst_hilo", HiLoOut, 64'h0);
    Rst = 1'b0;
    @(negedge Clk);

    // Pin the model with hand-computed values
    chk("model_mult",  model(4'd0, 32'hFFFF_FFFD, 32'd5, 64'h0), 64'hFFFF_FFFF_FFFF_FFF1);
    chk("model_divu",  model(4'd3, 32'd100, 32'd7, 64'h0),       64'h0000_0002_0000_000E);
    chk("model_div",   model(4'd2, 32'hFFFF_FFF9, 32'd2, 64'h0), 64'hFFFF_FFFF_FFFF_FFFD);
    chk("model_div0",  model(4'd2, 32'h1234_5678, 32'd0, 64'h0), 64'h1234_5678_FFFF_FFFF);
    chk("model_ovf",   model(4'd2, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0), 64'h0000_0000_8000_0000);
    chk("model_madd",  model(4'd4, 32'd2, 32'd3, 64'h10),        64'h16);
    chk("model_msubu", model(4'd7, 32'd1, 32'd1, 64'h0),         64'hFFFF_FFFF_FFFF_FFFF);

    // Directed operations against literal results and latencies
    run_op(4'd0, 32'hFFFF_FFFD, 32'd5, 64'h0, lat);
    chk("mult_lat", 64'(lat), 64'd34);
    chk("mult_res", HiLoOut, 64'hFFFF_FFFF_FFFF_FFF1);
    run_op(4'd3, 32'd100, 32'd7, 64'h0, lat);
    chk("divu_res", HiLoOut, 64'h0000_0002_0000_000E);
    run_op(4'd2, 32'hFFFF_FFF9, 32'd2, 64'h0, lat);
    chk("div_res", HiLoOut, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(4'd2, 32'h1234_5678, 32'd0, 64'h0, lat);
    chk("div0_lat", 64'(lat), 64'd2);
    chk("div0_res", HiLoOut, 64'h1234_5678_FFFF_FFFF);
    run_op(4'd2, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0, lat);
    chk("ovf_res", HiLoOut, 64'h0000_0000_8000_0000);
    run_op(4'd4, 32'd2, 32'd3, 64'h10, lat);
    chk("madd_res", HiLoOut, 64'h16);
    run_op(4'd7, 32'd1, 32'd1, 64'h0, lat);
    chk("msubu_res", HiLoOut, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op(4'd9, 32'hAB, 32'd0, 64'h1111_1111_2222_2222, lat);
    chk("mtlo_lat", 64'(lat), 64'd2);
    chk("mtlo_res", HiLoOut, 64'h1111_1111_0000_00AB);
    run_op(4'hF, 32'h5555, 32'd1, 64'h0, lat);
    chk("undef_lat", 64'(lat), 64'd2);
    chk("undef_res", HiLoOut, 64'h1111_1111_0000_00AB);

    // Start while busy is dropped
    wait_idle();
    d0 = done_cnt;
    start_op(4'd0, 32'hFFFF_FFFD, 32'd5, 64'h0);
    repeat (4) @(negedge Clk);
    start_op(4'd1, 32'd7, 32'd9, 64'h0);
    wait_idle();
    repeat (3) @(negedge Clk);
    chk("ign_dones", 64'(done_cnt - d0), 64'd1);
    chk("ign_res", HiLoOut, 64'hFFFF_FFFF_FFFF_FFF1);

    // Reset mid-divide aborts without a write
    d0 = done_cnt;
    start_op(4'd3, 32'd1000, 32'd3, 64'h0);
    repeat (9) @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    chk("abort_busy", 64'(Busy), 64'd0);
    chk("abort_done", 64'(Done), 64'd0);
    chk("abort_wren", 64'(HiLoWrEn), 64'd0);
    chk("abort_hilo", HiLoOut, 64'h0);
    repeat (40) @(negedge Clk);
    chk("abort_nodone", 64'(done_cnt - d0), 64'd0);

    // Randomized traffic, including spurious starts and occasional resets
    for (int i = 0; i < 250; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge Clk);
      rop = 4'($urandom_range(0, 11));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 15))
        0, 1: rb = 32'h0;
        2:    begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        3:    ra = 32'hFFFF_FFFF;
        4:    rb = 32'd1;
        default: ;
      endcase
      start_op(rop, ra, rb, {$urandom, $urandom});
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(0, 3)) @(negedge Clk);
        start_op(4'($urandom_range(0, 11)), $urandom, $urandom, {$urandom, $urandom});
      end
      if ($urandom_range(0, 24) == 0) begin
        repeat ($urandom_range(0, 20)) @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
      end
      wait_idle();
    end

    repeat (4) @(negedge Clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
